// File: rtl/hog_csr_pkg.sv
// Shared definitions for the hog CSR bank: response codes, register-map
// offsets that follow the RW and RO blocks, and small decode helpers.
package hog_csr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Class of a word index in the register map.
  typedef enum logic [2:0] {
    KIND_RW,
    KIND_RO,
    KIND_START,
    KIND_IRQ_STATUS,
    KIND_IRQ_MASK,
    KIND_UNMAPPED
  } reg_kind_e;

  // The control words sit directly after the RW and RO blocks.
  function automatic int unsigned START_IDX(input int unsigned num_rw,
                                            input int unsigned num_ro);
    return num_rw + num_ro;
  endfunction

  function automatic int unsigned IRQ_STATUS_IDX(input int unsigned num_rw,
                                                 input int unsigned num_ro);
    return START_IDX(num_rw, num_ro) + 1;
  endfunction

  function automatic int unsigned IRQ_MASK_IDX(input int unsigned num_rw,
                                               input int unsigned num_ro);
    return START_IDX(num_rw, num_ro) + 2;
  endfunction

  function automatic reg_kind_e decode_idx(input int unsigned idx,
                                           input int unsigned num_rw,
                                           input int unsigned num_ro);
    if (idx < num_rw)                                return KIND_RW;
    else if (idx < num_rw + num_ro)                  return KIND_RO;
    else if (idx == START_IDX(num_rw, num_ro))       return KIND_START;
    else if (idx == IRQ_STATUS_IDX(num_rw, num_ro))  return KIND_IRQ_STATUS;
    else if (idx == IRQ_MASK_IDX(num_rw, num_ro))    return KIND_IRQ_MASK;
    else                                             return KIND_UNMAPPED;
  endfunction

  // Expand a 4-bit write strobe into a 32-bit byte-lane mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/hog_csr_bank_irq_ctrl.sv
// Interrupt controller: rising-edge detect on level sources, W1C status
// (a new edge beats a same-cycle clear), byte-lane writable mask and a
// registered combined interrupt.
module hog_irq_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] src_i,
  input  logic               clr_we_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] wdata_i,
  input  logic [NUM_IRQ-1:0] bmask_i,
  output logic [NUM_IRQ-1:0] status_o,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic               irq_o
);

  logic [NUM_IRQ-1:0] src_prev_q;
  logic [NUM_IRQ-1:0] status_q, status_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               irq_q;

  // Next status and mask: clear first, then OR in new edges so set wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    status_d = status_q | (src_i & ~src_prev_q);
    mask_d   = mask_q;
    if (clr_we_i) begin
      status_d = (status_q & ~(wdata_i & bmask_i)) | (src_i & ~src_prev_q);
    end
    if (mask_we_i) begin
      mask_d = (mask_q & ~bmask_i) | (wdata_i & bmask_i);
    end
  end

  // State registers; irq lags status/mask by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst_i) begin
      src_prev_q <= '0;
      status_q   <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      src_prev_q <= src_i;
      status_q   <= status_d;
      mask_q     <= mask_d;
      irq_q      <= |(status_q & mask_q);
    end
  end

  assign status_o = status_q;
  assign mask_o   = mask_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/hog_csr_bank.sv
// AXI-Lite CSR bank: RW config words, RO status words, a write-1-to-pulse
// START word and an interrupt block. Write address and data are buffered
// independently and committed together; reads are a single-cycle lookup.
module hog_csr_bank
  import hog_csr_pkg::*;
#(
  parameter int AXIL_AW = 8,
  parameter int NUM_RW  = 16,
  parameter int NUM_RO  = 8,
  parameter int NUM_IRQ = 4
) (
  input  logic                  aclk,
  input  logic                  arest,
  input  logic [AXIL_AW-1:0]    s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [AXIL_AW-1:0]    s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [NUM_RW*32-1:0]  rw_regs,
  input  logic [NUM_RO*32-1:0]  ro_regs,
  output logic [31:0]           start_pulse,
  input  logic [NUM_IRQ-1:0]    irq_src,
  output logic                  irq
);

  localparam int IDX_W = AXIL_AW - 2;
  localparam int RW_IW = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
  localparam int RO_IW = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;

  // ---------------- write path ----------------
  logic             aw_full_q, w_full_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic             aw_hs, w_hs, commit;
  reg_kind_e        wr_kind;
  logic [1:0]       wr_resp;
  logic [31:0]      wr_bmask;

  logic [NUM_RW-1:0][31:0] rw_q;
  logic [31:0]             start_q;
  logic [NUM_IRQ-1:0]      irq_status, irq_mask;

  assign s_axil_awready = ~aw_full_q & ~bvalid_q & ~arest;
  assign s_axil_wready  = ~w_full_q & ~bvalid_q & ~arest;
  assign aw_hs          = s_axil_awvalid & s_axil_awready;
  assign w_hs           = s_axil_wvalid & s_axil_wready;
  assign commit         = aw_full_q & w_full_q;

  assign wr_kind  = decode_idx(int'(aw_idx_q), NUM_RW, NUM_RO);
  assign wr_resp  = (wr_kind == KIND_RO || wr_kind == KIND_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
  assign wr_bmask = strb_mask(w_strb_q);

  // AW/W one-entry buffers and the B channel; commit empties both buffers.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axil_awaddr[AXIL_AW-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if (bvalid_q && s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_resp;
      end
    end
  end

  // RW config words, updated per byte lane on commit.
  always_ff @(posedge aclk or posedge arest) begin
    // NOTE: this word array is small and must read as zero after reset, so it is reset like any flop rather than inferred as RAM.
    if (arest) begin
      rw_q <= '0;
    end else if (commit && wr_kind == KIND_RW) begin
      rw_q[aw_idx_q[RW_IW-1:0]] <= (rw_q[aw_idx_q[RW_IW-1:0]] & ~wr_bmask) | (w_data_q & wr_bmask);
    end
  end

  // START pulse: live for exactly the cycle after a START commit.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      start_q <= '0;
    end else begin
      start_q <= (commit && wr_kind == KIND_START) ? (w_data_q & wr_bmask) : '0;
    end
  end

  hog_irq_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_ctrl (
    .clk_i     (aclk),
    .rst_i     (arest),
    .src_i     (irq_src),
    .clr_we_i  (commit && wr_kind == KIND_IRQ_STATUS),
    .mask_we_i (commit && wr_kind == KIND_IRQ_MASK),
    .wdata_i   (w_data_q[NUM_IRQ-1:0]),
    .bmask_i   (wr_bmask[NUM_IRQ-1:0]),
    .status_o  (irq_status),
    .mask_o    (irq_mask),
    .irq_o     (irq)
  );

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign rw_regs       = rw_q;
  assign start_pulse   = start_q;

  // ---------------- read path ----------------
  logic [NUM_RO-1:0][31:0] ro_words;
  logic [IDX_W-1:0]        ar_idx, ro_off;
  reg_kind_e               rd_kind;
  logic [31:0]             rd_data;
  logic [1:0]              rd_resp;
  logic                    rvalid_q;
  logic [31:0]             rdata_q;
  logic [1:0]              rresp_q;
  logic                    ar_hs;

  assign ro_words       = ro_regs;
  assign ar_idx         = s_axil_araddr[AXIL_AW-1:2];
  assign ro_off         = ar_idx - IDX_W'(NUM_RW);
  assign rd_kind        = decode_idx(int'(ar_idx), NUM_RW, NUM_RO);
  assign s_axil_arready = ~rvalid_q & ~arest;
  assign ar_hs          = s_axil_arvalid & s_axil_arready;

  // Read lookup; reads see current (pre-commit) register contents.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_kind)
      KIND_RW:         rd_data = rw_q[ar_idx[RW_IW-1:0]];
      KIND_RO:         rd_data = ro_words[ro_off[RO_IW-1:0]];
      KIND_START:      rd_data = '0;
      KIND_IRQ_STATUS: rd_data = 32'(irq_status);
      KIND_IRQ_MASK:   rd_data = 32'(irq_mask);
      default:         rd_resp = RESP_SLVERR;
    endcase
  end

  // R channel: capture on AR handshake, hold until rready.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0],
                       s_axil_araddr[1:0], ar_idx, ro_off, aw_idx_q};

endmodule
